// File: rtl/lcd_frame_builder.sv
// Builds the 32-byte ASCII LCD frame (date, time, weekday, alarm) from a snapshot
// taken on each refresh tick, one byte per cycle, and drives the backlight enable.
//
// state  | meaning
// IDLE   | waiting for refresh tick; snapshot inputs on tick
// BUILD  | writing shadow byte idx_q (0..31)
// COMMIT | shadow copied to data_out, frame_valid pulsed
module lcd_frame_builder #(
    parameter int unsigned REFRESH_CYC    = 50_000,
    parameter int unsigned BLINK_CYC      = 25_000_000,
    parameter int unsigned BL_TIMEOUT_CYC = 500_000_000
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic [15:0]  year,
    input  logic [7:0]   month,
    input  logic [7:0]   day,
    input  logic [7:0]   hour,
    input  logic [7:0]   minute,
    input  logic [2:0]   weekday,
    input  logic         alarm_on,
    input  logic [2:0]   edit_field,
    input  logic         key_pulse,
    output logic [255:0] data_out,
    output logic         frame_valid,
    output logic         bl_en
);

    localparam int REF_W   = $clog2(REFRESH_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam int BL_W    = $clog2(BL_TIMEOUT_CYC + 1);

    localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
    localparam logic [BL_W-1:0]    BL_RELOAD  = BL_W'(BL_TIMEOUT_CYC);
    localparam logic [255:0]       BLANK_FRAME = {32{8'h20}};

    typedef enum logic [1:0] {IDLE, BUILD, COMMIT} state_t;

    state_t state_q, state_d;
    logic [4:0] idx_q, idx_d;

    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_hidden_q, blink_hidden_d;
    logic [BL_W-1:0]    bl_cnt_q, bl_cnt_d;

    logic [15:0] snap_year_q;
    logic [7:0]  snap_month_q, snap_day_q, snap_hour_q, snap_minute_q;
    logic [2:0]  snap_weekday_q, snap_field_q;
    logic        snap_alarm_q, snap_hidden_q;

    logic [255:0] shadow_q, shadow_d;
    logic [255:0] data_out_q;
    logic         frame_valid_q;

    logic       tick;
    logic       snap_en, shadow_we, commit;
    logic       edit_active;
    logic [7:0] cur_byte;

    function automatic logic [7:0] digit_char(input logic [3:0] nib, input logic blank);
        logic [7:0] c;
        if (blank)
            c = 8'h20;
        else if (nib <= 4'd9)
            c = 8'h30 + {4'h0, nib};
        else
            c = 8'h3F;
        return c;
    endfunction

    function automatic logic [7:0] day_char(input logic [2:0] wd, input logic [3:0] pos);
        logic [87:0] name;
        case (wd)
            3'd0:    name = {"Sunday",    {5{8'h20}}};
            3'd1:    name = {"Monday",    {5{8'h20}}};
            3'd2:    name = {"Tuesday",   {4{8'h20}}};
            3'd3:    name = {"Wednesday", {2{8'h20}}};
            3'd4:    name = {"Thursday",  {3{8'h20}}};
            3'd5:    name = {"Friday",    {5{8'h20}}};
            3'd6:    name = {"Saturday",  {3{8'h20}}};
            default: name = {"---",       {8{8'h20}}};
        endcase
        name = name << {pos, 3'b000};
        return name[87:80];
    endfunction

    assign tick        = (ref_cnt_q == REF_LAST);
    assign edit_active = (edit_field >= 3'd1) && (edit_field <= 3'd5);

    // Timers

    always_comb begin
        ref_cnt_d = tick ? '0 : ref_cnt_q + REF_W'(1);

        blink_cnt_d    = blink_cnt_q + BLINK_W'(1);
        blink_hidden_d = blink_hidden_q;
        if (key_pulse) begin
            blink_cnt_d    = '0;
            blink_hidden_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d    = '0;
            blink_hidden_d = ~blink_hidden_q;
        end

        if (key_pulse || edit_active)
            bl_cnt_d = BL_RELOAD;
        else if (bl_cnt_q != '0)
            bl_cnt_d = bl_cnt_q - BL_W'(1);
        else
            bl_cnt_d = '0;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
            bl_cnt_q       <= BL_RELOAD;
        end else begin
            ref_cnt_q      <= ref_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
            bl_cnt_q       <= bl_cnt_d;
        end
    end

    // FSM

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = BUILD;
                    idx_d   = '0;
                end
            end
            BUILD: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31)
                    state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A tick outside IDLE is ignored because snap_en is gated by state.
    always_comb begin
        snap_en   = (state_q == IDLE) && tick;
        shadow_we = (state_q == BUILD);
        commit    = (state_q == COMMIT);
    end

    // Snapshot

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            snap_year_q    <= '0;
            snap_month_q   <= '0;
            snap_day_q     <= '0;
            snap_hour_q    <= '0;
            snap_minute_q  <= '0;
            snap_weekday_q <= '0;
            snap_field_q   <= '0;
            snap_alarm_q   <= 1'b0;
            snap_hidden_q  <= 1'b0;
        end else if (snap_en) begin
            snap_year_q    <= year;
            snap_month_q   <= month;
            snap_day_q     <= day;
            snap_hour_q    <= hour;
            snap_minute_q  <= minute;
            snap_weekday_q <= weekday;
            snap_field_q   <= edit_field;
            snap_alarm_q   <= alarm_on;
            snap_hidden_q  <= blink_hidden_q;
        end
    end

    // Byte generator

    always_comb begin
        logic hb_year, hb_month, hb_day, hb_hour, hb_minute;
        hb_year   = snap_hidden_q && (snap_field_q == 3'd1);
        hb_month  = snap_hidden_q && (snap_field_q == 3'd2);
        hb_day    = snap_hidden_q && (snap_field_q == 3'd3);
        hb_hour   = snap_hidden_q && (snap_field_q == 3'd4);
        hb_minute = snap_hidden_q && (snap_field_q == 3'd5);
        cur_byte  = 8'h20;
        case (idx_q)
            5'd0:  cur_byte = digit_char(snap_year_q[15:12], hb_year);
            5'd1:  cur_byte = digit_char(snap_year_q[11:8],  hb_year);
            5'd2:  cur_byte = digit_char(snap_year_q[7:4],   hb_year);
            5'd3:  cur_byte = digit_char(snap_year_q[3:0],   hb_year);
            5'd4:  cur_byte = "-";
            5'd5:  cur_byte = digit_char(snap_month_q[7:4],  hb_month);
            5'd6:  cur_byte = digit_char(snap_month_q[3:0],  hb_month);
            5'd7:  cur_byte = "-";
            5'd8:  cur_byte = digit_char(snap_day_q[7:4],    hb_day);
            5'd9:  cur_byte = digit_char(snap_day_q[3:0],    hb_day);
            5'd10: cur_byte = 8'h20;
            5'd11: cur_byte = digit_char(snap_hour_q[7:4],   hb_hour);
            5'd12: cur_byte = digit_char(snap_hour_q[3:0],   hb_hour);
            5'd13: cur_byte = ":";
            5'd14: cur_byte = digit_char(snap_minute_q[7:4], hb_minute);
            5'd15: cur_byte = digit_char(snap_minute_q[3:0], hb_minute);
            5'd27: cur_byte = snap_alarm_q ? "A" : 8'h20;
            5'd28: cur_byte = snap_alarm_q ? "l" : 8'h20;
            5'd29: cur_byte = snap_alarm_q ? "a" : 8'h20;
            5'd30: cur_byte = snap_alarm_q ? "r" : 8'h20;
            5'd31: cur_byte = snap_alarm_q ? "m" : 8'h20;
            default: cur_byte = day_char(snap_weekday_q, 4'(idx_q - 5'd16));
        endcase
    end

    // Shadow and committed frame

    always_comb begin
        shadow_d = shadow_q;
        if (shadow_we)
            shadow_d[{idx_q, 3'b000} +: 8] = cur_byte;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= BLANK_FRAME;
            data_out_q    <= BLANK_FRAME;
            frame_valid_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            frame_valid_q <= commit;
            if (commit)
                data_out_q <= shadow_q;
        end
    end

    assign data_out    = data_out_q;
    assign frame_valid = frame_valid_q;
    assign bl_en       = (bl_cnt_q != '0);

endmodule

// File: doc/lcd_frame_builder.md
# lcd_frame_builder

Formats the clock's current date, time, weekday and alarm state into the 32-byte ASCII frame consumed by the LCD driver. It also generates that driver's backlight enable. The block sits directly upstream of the LCD driver and downstream of the timekeeping and key-handling logic. It snapshots its inputs on a periodic refresh tick, builds the frame one byte per cycle into a shadow register, then commits the whole frame atomically.

## Interface
- REFRESH_CYC, 50_000: clock cycles between frame rebuilds (1 ms at 50 MHz); must be ≥ 40.
- BLINK_CYC, 25_000_000: cycles per blink half-period of the field being edited.
- BL_TIMEOUT_CYC, 500_000_000: idle cycles before the backlight turns off (10 s).
- CLOCK_50  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- year  input  16  BCD year, thousands digit in [15:12].
- month, day, hour, minute  input  8 each  BCD, tens digit in [7:4].
- weekday  input  3  0 = Sunday … 6 = Saturday.
- alarm_on  input  1  alarm armed.
- edit_field  input  3  0 none, 1 year, 2 month, 3 day, 4 hour, 5 minute; 6–7 treated as 0.
- key_pulse  input  1  one-cycle pulse on any key press.
- data_out  output  256  frame; byte k occupies [8k+7:8k].
- frame_valid  output  1  one-cycle pulse when data_out updates.
- bl_en  output  1  backlight enable.

## Operation
- Byte map, row 1:
  - Bytes 0–3: year digits, thousands first.
  - Byte 4: '-'. Bytes 5–6: month.
  - Byte 7: '-'. Bytes 8–9: day.
  - Byte 10: ' '. Bytes 11–12: hour.
  - Byte 13: ':'. Bytes 14–15: minute.
- Byte map, row 2:
  - Bytes 16–26: weekday name ("Sunday", "Monday", "Tuesday", "Wednesday", "Thursday", "Friday", "Saturday"), left-justified and space-padded. weekday = 7 renders "---" plus padding.
  - Bytes 27–31: "Alarm" when alarm_on, else five spaces.
- Digit conversion: nibble 0–9 → 8'h30 + nibble; nibble A–F → '?' (8'h3F).
- FSM states:
  - IDLE: on refresh tick, capture all inputs and the blink phase into snapshot registers → BUILD.
  - BUILD: byte index 0..31, one shadow byte written per cycle; after index 31 → COMMIT.
  - COMMIT: shadow → data_out, frame_valid = 1 → IDLE.
- Refresh counter:
  - Free-running, 0..REFRESH_CYC-1; tick when it equals REFRESH_CYC-1, then wraps to 0.
  - The counter runs in every state. The parameter constraint guarantees a tick never lands outside IDLE; if one does, it is ignored.
- Blink:
  - Phase toggles every BLINK_CYC cycles.
  - When the snapshot phase is "hidden", the digits of the snapshot edit_field render as spaces. Separators are never blanked.
  - key_pulse restarts the blink counter and forces phase "visible".
- Backlight:
  - Counter reloads BL_TIMEOUT_CYC on reset, on key_pulse, and on every cycle with edit_field ∈ 1..5.
  - Otherwise it decrements, saturating at 0.
  - bl_en = (counter ≠ 0).
- Inputs changing during BUILD do not affect the frame in progress.

## Timing
- Tick in cycle T:
  - Snapshot registered at end of T.
  - Shadow byte k written at end of T+1+k.
  - data_out and frame_valid registered at end of T+33, visible during T+34.
  - frame_valid is high exactly one cycle per frame.
- First tick after reset occurs REFRESH_CYC-1 cycles after rst_n deasserts. The first committed frame is therefore visible at cycle REFRESH_CYC+33.
- Reset values:
  - data_out = 32 × 8'h20; frame_valid = 0; bl_en = 1.
  - FSM = IDLE; refresh counter = 0; blink counter = 0; blink phase = visible; backlight counter = BL_TIMEOUT_CYC.
- Reset asserted mid-BUILD: the shadow is discarded, outputs return to reset values immediately (asynchronously), and no partial frame is ever committed.
- key_pulse coincident with the blink toggle: key_pulse wins (phase visible, counter 0).
- key_pulse coincident with the backlight counter reaching 0: reload wins; bl_en stays 1.

## Test plan
- **Basic frame.** Reset, then year=16'h2024, month=8'h03, day=8'h15, hour=8'h09, minute=8'h41, weekday=5, alarm_on=1. Required at the first frame_valid: row 1 reads "2024-03-15 09:41", row 2 reads "Friday     Alarm". frame_valid pulses at cycle REFRESH_CYC+33 after release.
- **Invalid values.** minute=8'h5C, weekday=7. Required: byte 15 = 8'h3F ('?'), bytes 16–18 = "---", bytes 19–26 = spaces.
- **Blink.** Use BLINK_CYC=100, edit_field=4. Required: bytes 11–12 alternate between the hour digits and 8'h20 every 100 cycles, while byte 13 stays ':'. A key_pulse while hidden makes the next frame show the digits.
- **Backlight timeout.** Use BL_TIMEOUT_CYC=50, edit_field=0. Required: bl_en falls exactly 50 cycles after reset release. key_pulse raises it on the next cycle; edit_field=2 holds it high indefinitely.
- **Atomicity.** Change every time input at T+10 of a build. Required: the committed frame contains only values captured at T, and the change appears in the following frame.
- **Mid-build reset.** Assert rst_n low at T+20. Required: data_out becomes all 8'h20 with no frame_valid pulse. Normal operation resumes after release.
